// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_pkg
//  Brief    : Shared encodings and limits for the traffic-phase controller
//             and the display drivers that consume its outputs.
//  Revision : 1.0  initial release
// ============================================================================
package traffic_pkg;

  // Largest duration a two-digit seven-segment display can show.
  localparam int MAX_SECONDS = 99;

  // Phase encoding as seen on the phase output.
  typedef enum logic [2:0] {
    PH_GREEN  = 3'd0,
    PH_FLASH  = 3'd1,
    PH_YELLOW = 3'd2,
    PH_ALLRED = 3'd3,
    PH_NIGHT  = 3'd4
  } phase_e;

  // Pedestrian signal encoding, two bits per direction.
  typedef enum logic [1:0] {
    PED_STOP  = 2'd0,
    PED_WALK  = 2'd1,
    PED_HURRY = 2'd2
  } ped_e;

endpackage : traffic_pkg
`default_nettype wire

// File: rtl/bcd_split.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_split
//  Brief    : Combinational 7-bit binary to two-digit BCD {tens, ones}.
//             Inputs above 99 produce a non-BCD tens digit.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_split (
  input  logic [6:0] bin_i,
  output logic [7:0] bcd_o
);

  logic [3:0] w_tens;
  logic [3:0] w_ones;

  assign w_tens = 4'(bin_i / 7'd10);
  assign w_ones = 4'(bin_i - (7'(w_tens) * 7'd10));
  assign bcd_o  = {w_tens, w_ones};

endmodule : bcd_split
`default_nettype wire

// File: rtl/traffic_phase_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_phase_ctrl
//  Brief    : N-direction round-robin traffic-light sequencer with
//             programmable phase durations, pedestrian request latching and
//             green truncation, per-direction walk/hurry/stop and night blink.
//  Revision : 1.0  initial release
// ============================================================================
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_DIR  = 2,
  parameter int GREEN_S  = 20,
  parameter int FLASH_S  = 5,
  parameter int YELLOW_S = 4,
  parameter int ALLRED_S = 1,
  parameter int PED_CUT  = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick_1s,
  input  logic                   tick_blink,
  input  logic                   night,
  input  logic [NUM_DIR-1:0]     ped_req,
  output logic [NUM_DIR-1:0]     light_r,
  output logic [NUM_DIR-1:0]     light_y,
  output logic [NUM_DIR-1:0]     light_g,
  output logic [1:0]             active_dir,
  output logic [2:0]             phase,
  output logic [6:0]             remain,
  output logic [7:0]             remain_bcd,
  output logic [2*NUM_DIR-1:0]   ped_state
);

  // Illegal parameter sets are rejected at elaboration time.
  if (NUM_DIR < 2 || NUM_DIR > 4 ||
      GREEN_S  < 1 || GREEN_S  > MAX_SECONDS ||
      FLASH_S  < 1 || FLASH_S  > MAX_SECONDS ||
      YELLOW_S < 1 || YELLOW_S > MAX_SECONDS ||
      ALLRED_S < 1 || ALLRED_S > MAX_SECONDS ||
      PED_CUT  < 1 || PED_CUT  >= GREEN_S) begin : g_param_check
    $error("traffic_phase_ctrl: illegal parameter set");
  end

  localparam logic [6:0] c_GREEN_S  = 7'(GREEN_S);
  localparam logic [6:0] c_FLASH_S  = 7'(FLASH_S);
  localparam logic [6:0] c_YELLOW_S = 7'(YELLOW_S);
  localparam logic [6:0] c_ALLRED_S = 7'(ALLRED_S);
  localparam logic [6:0] c_PED_CUT  = 7'(PED_CUT);
  localparam logic [1:0] c_LAST_DIR = 2'(NUM_DIR - 1);

  phase_e               phase_q, phase_d;
  logic [1:0]           dir_q, dir_d;
  logic [6:0]           remain_q, remain_d;
  logic                 blink_q, blink_d;
  logic [NUM_DIR-1:0]   pend_q, pend_d;
  logic [NUM_DIR-1:0]   lamp_r_q, lamp_r_d;
  logic [NUM_DIR-1:0]   lamp_y_q, lamp_y_d;
  logic [NUM_DIR-1:0]   lamp_g_q, lamp_g_d;
  logic [2*NUM_DIR-1:0] ped_q, ped_d;

  logic [1:0]           w_dir_next;
  logic                 w_other_pend;
  logic                 w_trunc;

  assign w_dir_next = (dir_q == c_LAST_DIR) ? 2'd0 : dir_q + 2'd1;

  // Any pending pedestrian request on a direction other than the active one.
  always_comb begin
    w_other_pend = 1'b0;
    for (int j = 0; j < NUM_DIR; j++) begin
      if (dir_q != 2'(j)) w_other_pend = w_other_pend | pend_q[j];
    end
    w_trunc = (phase_q == PH_GREEN) && w_other_pend && (remain_q > c_PED_CUT);
  end

  // Next phase, direction, countdown, pedestrian latch and blink phase.
  always_comb begin
    phase_d  = phase_q;
    dir_d    = dir_q;
    remain_d = remain_q;
    blink_d  = blink_q ^ tick_blink;
    pend_d   = pend_q | ped_req;
    if (night) begin
      phase_d  = PH_NIGHT;
      remain_d = 7'd0;
      pend_d   = '0;
    end else if (phase_q == PH_NIGHT) begin
      // Leaving night restarts from the reset state.
      phase_d  = PH_ALLRED;
      dir_d    = c_LAST_DIR;
      remain_d = c_ALLRED_S;
      blink_d  = 1'b1;
      pend_d   = '0;
    end else if (w_trunc) begin
      // Truncation load wins over a coincident second tick.
      remain_d = c_PED_CUT;
    end else if (tick_1s) begin
      if (remain_q == 7'd1) begin
        case (phase_q)
          PH_GREEN: begin
            phase_d  = PH_FLASH;
            remain_d = c_FLASH_S;
          end
          PH_FLASH: begin
            phase_d  = PH_YELLOW;
            remain_d = c_YELLOW_S;
          end
          PH_YELLOW: begin
            phase_d  = PH_ALLRED;
            remain_d = c_ALLRED_S;
          end
          default: begin
            phase_d  = PH_GREEN;
            dir_d    = w_dir_next;
            remain_d = c_GREEN_S;
            // Served request clears, but one arriving this cycle is kept.
            for (int j = 0; j < NUM_DIR; j++) begin
              if (w_dir_next == 2'(j)) pend_d[j] = ped_req[j];
            end
          end
        endcase
      end else begin
        remain_d = remain_q - 7'd1;
      end
    end
  end

  // Lamp and pedestrian decode from the next state so outputs stay aligned with phase.
  always_comb begin
    lamp_r_d = '1;
    lamp_y_d = '0;
    lamp_g_d = '0;
    ped_d    = '0;
    for (int j = 0; j < NUM_DIR; j++) begin
      if (phase_d == PH_NIGHT) begin
        lamp_r_d[j] = 1'b0;
        lamp_y_d[j] = blink_d;
      end else if (dir_d == 2'(j)) begin
        case (phase_d)
          PH_GREEN: begin
            lamp_r_d[j]      = 1'b0;
            lamp_g_d[j]      = 1'b1;
            ped_d[2*j +: 2]  = PED_WALK;
          end
          PH_FLASH: begin
            lamp_r_d[j]      = 1'b0;
            lamp_g_d[j]      = blink_d;
            ped_d[2*j +: 2]  = PED_HURRY;
          end
          PH_YELLOW: begin
            lamp_r_d[j]      = 1'b0;
            lamp_y_d[j]      = 1'b1;
          end
          default: begin
            lamp_r_d[j]      = 1'b1;
          end
        endcase
      end
    end
  end

  // Phase FSM state and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= PH_ALLRED;
      dir_q    <= c_LAST_DIR;
      remain_q <= c_ALLRED_S;
      blink_q  <= 1'b1;
      pend_q   <= '0;
      lamp_r_q <= '1;
      lamp_y_q <= '0;
      lamp_g_q <= '0;
      ped_q    <= '0;
    end else begin
      phase_q  <= phase_d;
      dir_q    <= dir_d;
      remain_q <= remain_d;
      blink_q  <= blink_d;
      pend_q   <= pend_d;
      lamp_r_q <= lamp_r_d;
      lamp_y_q <= lamp_y_d;
      lamp_g_q <= lamp_g_d;
      ped_q    <= ped_d;
    end
  end

  assign light_r    = lamp_r_q;
  assign light_y    = lamp_y_q;
  assign light_g    = lamp_g_q;
  assign active_dir = dir_q;
  assign phase      = phase_q;
  assign remain     = remain_q;
  assign ped_state  = ped_q;

  bcd_split u_bcd (
    .bin_i (remain_q),
    .bcd_o (remain_bcd)
  );

endmodule : traffic_phase_ctrl
`default_nettype wire
